// File: rtl/cpu_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_regfile_pkg
//  Description : Shared constants and helpers for the CPU register file and
//                its load-use scoreboard.
//                ZERO_REG   - hard-wired zero register index
//                LINK_REG   - jal link register index
//                DEF_DATA_W - default register width
//                clog2()    - constant-evaluable ceil(log2(value))
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_regfile_pkg;

   localparam int ZERO_REG   = 0;
   localparam int LINK_REG   = 31;
   localparam int DEF_DATA_W = 32;

   // ceil(log2(value)); returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_busy_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_busy_tracker
//  Description : Load scoreboard. Holds the per-register busy mask, the
//                outstanding-load counter, full detection and the sticky
//                protocol-error flag.
//  Ports       : iCpuClock, iCpuReset (async, active-high)
//                i_ld_issue / i_ld_addr        - load issue and destination
//                i_ld_done / i_ld_done_addr    - load return and destination
//                i_wr_en / i_wr_addr           - ALU writeback (error checks)
//                o_busy_mask                   - busy bit per register
//                o_ld_count / o_ld_full        - outstanding loads / at cap
//                o_err                         - sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
import cpu_regfile_pkg::*;

module regfile_busy_tracker #(
   parameter  int REG_CNT   = 32,
   parameter  int MAX_LOADS = 4,
   localparam int ADDR_W    = clog2(REG_CNT),
   localparam int CNT_W     = clog2(MAX_LOADS + 1)
) (
   input  logic                iCpuClock,
   input  logic                iCpuReset,
   input  logic                i_ld_issue,
   input  logic [ADDR_W-1:0]   i_ld_addr,
   input  logic                i_ld_done,
   input  logic [ADDR_W-1:0]   i_ld_done_addr,
   input  logic                i_wr_en,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   output logic [REG_CNT-1:0]  o_busy_mask,
   output logic [CNT_W-1:0]    o_ld_count,
   output logic                o_ld_full,
   output logic                o_err
);

   logic [REG_CNT-1:0] r_busy;
   logic [CNT_W-1:0]   r_count;
   logic               r_err;

   logic               w_full;
   logic               w_done_ok;
   logic               w_issue_ok;
   logic               w_ld_nz;
   logic               w_wr_nz;
   logic               w_done_nz;
   logic [REG_CNT-1:0] w_busy_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic               w_err_evt;

   assign w_full    = (r_count == CNT_W'(MAX_LOADS));
   assign w_ld_nz   = (i_ld_addr      != ADDR_W'(ZERO_REG));
   assign w_wr_nz   = (i_wr_addr      != ADDR_W'(ZERO_REG));
   assign w_done_nz = (i_ld_done_addr != ADDR_W'(ZERO_REG));

   // A return with nothing outstanding only writes data; it never touches
   // the scoreboard.
   assign w_done_ok  = i_ld_done && (r_count != '0);
   // When full, a same-cycle return frees the slot the new issue takes.
   assign w_issue_ok = i_ld_issue && (!w_full || i_ld_done);

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_done_ok) begin
         w_busy_nxt[i_ld_done_addr] = 1'b0;
      end
      // Issue is applied last: the new load is younger than the returning one.
      if (w_issue_ok && w_ld_nz) begin
         w_busy_nxt[i_ld_addr] = 1'b1;
      end
      w_busy_nxt[ZERO_REG] = 1'b0;
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_issue_ok, w_done_ok})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_err_evt = 1'b0;
      // WAW on a pending load. Not an error when that same load retires in
      // this cycle, since the register is then no longer pending.
      if (i_ld_issue && w_ld_nz && r_busy[i_ld_addr] &&
          !(w_done_ok && w_done_nz && (i_ld_done_addr == i_ld_addr))) begin
         w_err_evt = 1'b1;
      end
      if (i_ld_issue && w_full && !i_ld_done) begin
         w_err_evt = 1'b1;
      end
      if (i_ld_done && (r_count == '0)) begin
         w_err_evt = 1'b1;
      end
      if (i_wr_en && w_wr_nz && r_busy[i_wr_addr]) begin
         w_err_evt = 1'b1;
      end
      if (i_wr_en && i_ld_done && w_wr_nz && (i_wr_addr == i_ld_done_addr)) begin
         w_err_evt = 1'b1;
      end
   end

   always_ff @(posedge iCpuClock or posedge iCpuReset) begin
      if (iCpuReset) begin
         r_busy  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_count <= w_count_nxt;
         r_err   <= r_err | w_err_evt;
      end
   end

   assign o_busy_mask = r_busy;
   assign o_ld_count  = r_count;
   assign o_ld_full   = w_full;
   assign o_err       = r_err;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : REG_CNT x DATA_W register file with two combinational read
//                ports, ALU and load-return write ports, and a load-use
//                scoreboard that stalls reads of registers awaiting a load.
//                Build option: REGFILE_BYPASS_EN - forward same-cycle write
//                data to the read ports and un-stall on a returning load.
//  Ports       : iCpuClock, iCpuReset (async, active-high)
//                iRs, iRt -> oDataRead1, oDataRead2   read ports
//                iWrEn, iWrAddr, iWrData              ALU writeback
//                iLdIssue, iLdAddr                    load issue
//                iLdDone, iLdDoneAddr, iLdData        load return
//                oStall, oBusyMask, oLdCount, oLdFull, oErr  scoreboard status
//  Revision    : 1.0 - initial release
// ============================================================================
import cpu_regfile_pkg::*;

module regfile_scoreboard #(
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int REG_CNT   = 32,
   parameter  int MAX_LOADS = 4,
   localparam int ADDR_W    = clog2(REG_CNT),
   localparam int CNT_W     = clog2(MAX_LOADS + 1)
) (
   input  logic                iCpuClock,
   input  logic                iCpuReset,
   input  logic [ADDR_W-1:0]   iRs,
   input  logic [ADDR_W-1:0]   iRt,
   output logic [DATA_W-1:0]   oDataRead1,
   output logic [DATA_W-1:0]   oDataRead2,
   input  logic                iWrEn,
   input  logic [ADDR_W-1:0]   iWrAddr,
   input  logic [DATA_W-1:0]   iWrData,
   input  logic                iLdIssue,
   input  logic [ADDR_W-1:0]   iLdAddr,
   input  logic                iLdDone,
   input  logic [ADDR_W-1:0]   iLdDoneAddr,
   input  logic [DATA_W-1:0]   iLdData,
   output logic                oStall,
   output logic [REG_CNT-1:0]  oBusyMask,
   output logic [CNT_W-1:0]    oLdCount,
   output logic                oLdFull,
   output logic                oErr
);

   // Entry 0 is only ever loaded with zero, so reads of R0 return 0.
   logic [DATA_W-1:0]  r_regs [REG_CNT];

   logic               w_alu_we;
   logic               w_ld_we;
   logic [REG_CNT-1:0] w_busy;
   logic [REG_CNT-1:0] w_stall_mask;
   logic [DATA_W-1:0]  w_rd1;
   logic [DATA_W-1:0]  w_rd2;

   assign w_alu_we = iWrEn   && (iWrAddr     != ADDR_W'(ZERO_REG));
   assign w_ld_we  = iLdDone && (iLdDoneAddr != ADDR_W'(ZERO_REG));

   regfile_busy_tracker #(
      .REG_CNT   (REG_CNT),
      .MAX_LOADS (MAX_LOADS)
   ) u_busy_tracker (
      .iCpuClock      (iCpuClock),
      .iCpuReset      (iCpuReset),
      .i_ld_issue     (iLdIssue),
      .i_ld_addr      (iLdAddr),
      .i_ld_done      (iLdDone),
      .i_ld_done_addr (iLdDoneAddr),
      .i_wr_en        (iWrEn),
      .i_wr_addr      (iWrAddr),
      .o_busy_mask    (w_busy),
      .o_ld_count     (oLdCount),
      .o_ld_full      (oLdFull),
      .o_err          (oErr)
   );

   // Load data wins over ALU data when both target the same register.
   always_ff @(posedge iCpuClock or posedge iCpuReset) begin
      if (iCpuReset) begin
         for (int i = 0; i < REG_CNT; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < REG_CNT; i++) begin
            if (w_ld_we && (iLdDoneAddr == ADDR_W'(i))) begin
               r_regs[i] <= iLdData;
            end else if (w_alu_we && (iWrAddr == ADDR_W'(i))) begin
               r_regs[i] <= iWrData;
            end
         end
      end
   end

   always_comb begin
      w_rd1 = r_regs[iRs];
      w_rd2 = r_regs[iRt];
`ifdef REGFILE_BYPASS_EN
      if (w_ld_we && (iLdDoneAddr == iRs)) begin
         w_rd1 = iLdData;
      end else if (w_alu_we && (iWrAddr == iRs)) begin
         w_rd1 = iWrData;
      end
      if (w_ld_we && (iLdDoneAddr == iRt)) begin
         w_rd2 = iLdData;
      end else if (w_alu_we && (iWrAddr == iRt)) begin
         w_rd2 = iWrData;
      end
`endif
   end

   always_comb begin
      w_stall_mask = w_busy;
`ifdef REGFILE_BYPASS_EN
      // The returning data is forwarded, so its register need not stall.
      if (iLdDone) begin
         w_stall_mask[iLdDoneAddr] = 1'b0;
      end
`endif
   end

   assign oDataRead1 = w_rd1;
   assign oDataRead2 = w_rd2;
   assign oStall     = w_stall_mask[iRs] | w_stall_mask[iRt];
   assign oBusyMask  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed, table-driven bench for regfile_scoreboard
//                (DATA_W=32, REG_CNT=32, MAX_LOADS=4) plus hand-written
//                multi-cycle sequences. Honours REGFILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

   logic        iCpuClock;
   logic        iCpuReset;
   logic [4:0]  iRs, iRt;
   logic [31:0] oDataRead1, oDataRead2;
   logic        iWrEn;
   logic [4:0]  iWrAddr;
   logic [31:0] iWrData;
   logic        iLdIssue;
   logic [4:0]  iLdAddr;
   logic        iLdDone;
   logic [4:0]  iLdDoneAddr;
   logic [31:0] iLdData;
   logic        oStall;
   logic [31:0] oBusyMask;
   logic [2:0]  oLdCount;
   logic        oLdFull;
   logic        oErr;

   int total = 0;
   int bad   = 0;

   regfile_scoreboard #(
      .DATA_W    (32),
      .REG_CNT   (32),
      .MAX_LOADS (4)
   ) dut (
      .iCpuClock   (iCpuClock),
      .iCpuReset   (iCpuReset),
      .iRs         (iRs),
      .iRt         (iRt),
      .oDataRead1  (oDataRead1),
      .oDataRead2  (oDataRead2),
      .iWrEn       (iWrEn),
      .iWrAddr     (iWrAddr),
      .iWrData     (iWrData),
      .iLdIssue    (iLdIssue),
      .iLdAddr     (iLdAddr),
      .iLdDone     (iLdDone),
      .iLdDoneAddr (iLdDoneAddr),
      .iLdData     (iLdData),
      .oStall      (oStall),
      .oBusyMask   (oBusyMask),
      .oLdCount    (oLdCount),
      .oLdFull     (oLdFull),
      .oErr        (oErr)
   );

   initial iCpuClock = 1'b0;
   always #5 iCpuClock = ~iCpuClock;

   typedef struct {
      logic        we;  logic [4:0] wa;  logic [31:0] wd;
      logic        li;  logic [4:0] la;
      logic        ld;  logic [4:0] lda; logic [31:0] ldd;
      logic [4:0]  rs;  logic [4:0] rt;
      logic [31:0] e1;  logic [31:0] e2; logic es;
      logic [31:0] em;  logic [2:0] ec;  logic ef; logic ee; logic ce;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      iWrEn = 0; iWrAddr = 0; iWrData = 0;
      iLdIssue = 0; iLdAddr = 0;
      iLdDone = 0; iLdDoneAddr = 0; iLdData = 0;
   endtask

   // Let the edge happen, drop all strobes, then settle before sampling.
   task automatic step();
      @(posedge iCpuClock);
      #1;
      iWrEn = 0; iLdIssue = 0; iLdDone = 0;
      #1;
   endtask

   task automatic do_reset();
      @(negedge iCpuClock);
      idle();
      iCpuReset = 1;
      #2;
      iCpuReset = 0;
   endtask

   initial begin
      //            we wa     wd            li la     ld lda    ldd           rs     rt     e1            e2            es  em             ec    ef  ee  ce
      vecs[0]  = '{1, 5'd5,  32'h1234,     0, 5'd0,  0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h1234,     32'h0,        0,  32'h0,         3'd0, 0,  0,  1};
      vecs[1]  = '{1, 5'd0,  32'hDEAD,     0, 5'd0,  0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h1234,     0,  32'h0,         3'd0, 0,  0,  1};
      vecs[2]  = '{0, 5'd0,  32'h0,        1, 5'd8,  0, 5'd0,  32'h0,        5'd5,  5'd8,  32'h1234,     32'h0,        1,  32'h100,       3'd1, 0,  0,  1};
      vecs[3]  = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd8,  32'hCAFE,     5'd8,  5'd5,  32'hCAFE,     32'h1234,     0,  32'h0,         3'd0, 0,  0,  1};
      vecs[4]  = '{0, 5'd0,  32'h0,        1, 5'd1,  0, 5'd0,  32'h0,        5'd1,  5'd0,  32'h0,        32'h0,        1,  32'h2,         3'd1, 0,  0,  1};
      vecs[5]  = '{0, 5'd0,  32'h0,        1, 5'd2,  0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        0,  32'h6,         3'd2, 0,  0,  1};
      vecs[6]  = '{0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        0,  32'hE,         3'd3, 0,  0,  1};
      vecs[7]  = '{0, 5'd0,  32'h0,        1, 5'd4,  0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        0,  32'h1E,        3'd4, 1,  0,  1};
      vecs[8]  = '{0, 5'd0,  32'h0,        1, 5'd3,  1, 5'd3,  32'h33,       5'd3,  5'd0,  32'h33,       32'h0,        1,  32'h1E,        3'd4, 1,  0,  0};
      vecs[9]  = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd4,  32'h44,       5'd4,  5'd0,  32'h44,       32'h0,        0,  32'hE,         3'd3, 0,  0,  0};
      vecs[10] = '{0, 5'd0,  32'h0,        1, 5'd4,  0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        0,  32'h1E,        3'd4, 1,  0,  0};
      vecs[11] = '{0, 5'd0,  32'h0,        1, 5'd9,  0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h0,        32'h0,        0,  32'h1E,        3'd4, 1,  1,  1};
      vecs[12] = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd1,  32'h111,      5'd1,  5'd2,  32'h111,      32'h0,        1,  32'h1C,        3'd3, 0,  1,  1};

      idle();
      iRs = 5'd5; iRt = 5'd8;
      iCpuReset = 1;
      #12;
      chk("reset rd1",   oDataRead1, 0);
      chk("reset rd2",   oDataRead2, 0);
      chk("reset stall", oStall,     0);
      chk("reset mask",  oBusyMask,  0);
      chk("reset cnt",   oLdCount,   0);
      chk("reset full",  oLdFull,    0);
      chk("reset err",   oErr,       0);
      @(negedge iCpuClock);
      iCpuReset = 0;

      for (int i = 0; i < 13; i++) begin
         @(negedge iCpuClock);
         iWrEn = vecs[i].we; iWrAddr = vecs[i].wa; iWrData = vecs[i].wd;
         iLdIssue = vecs[i].li; iLdAddr = vecs[i].la;
         iLdDone = vecs[i].ld; iLdDoneAddr = vecs[i].lda; iLdData = vecs[i].ldd;
         iRs = vecs[i].rs; iRt = vecs[i].rt;
         step();
         chk($sformatf("v%0d rd1", i),   oDataRead1, vecs[i].e1);
         chk($sformatf("v%0d rd2", i),   oDataRead2, vecs[i].e2);
         chk($sformatf("v%0d stall", i), oStall,     vecs[i].es);
         chk($sformatf("v%0d mask", i),  oBusyMask,  vecs[i].em);
         chk($sformatf("v%0d cnt", i),   oLdCount,   vecs[i].ec);
         chk($sformatf("v%0d full", i),  oLdFull,    vecs[i].ef);
         if (vecs[i].ce) chk($sformatf("v%0d err", i), oErr, vecs[i].ee);
      end

      // Asynchronous reset mid-cycle with three loads outstanding.
      @(negedge iCpuClock);
      iRs = 5'd1; iRt = 5'd2;
      #2;
      iCpuReset = 1;
      #1;
      chk("arst cnt",  oLdCount,   0);
      chk("arst mask", oBusyMask,  0);
      chk("arst rd1",  oDataRead1, 0);
      chk("arst err",  oErr,       0);
      chk("arst stall", oStall,    0);
      #1;
      iCpuReset = 0;

      // Return with nothing outstanding: data written, error raised.
      @(negedge iCpuClock);
      iLdDone = 1; iLdDoneAddr = 5'd6; iLdData = 32'h66; iRs = 5'd6; iRt = 5'd0;
      step();
      chk("udf rd1", oDataRead1, 32'h66);
      chk("udf err", oErr,       1);
      chk("udf cnt", oLdCount,   0);

      // ALU and load writing the same register: load wins, error raised.
      do_reset();
      @(negedge iCpuClock);
      iLdIssue = 1; iLdAddr = 5'd10;
      step();
      chk("coll pre err", oErr,     0);
      chk("coll pre cnt", oLdCount, 1);
      @(negedge iCpuClock);
      iWrEn = 1; iWrAddr = 5'd7; iWrData = 32'h11;
      iLdDone = 1; iLdDoneAddr = 5'd7; iLdData = 32'h22; iRs = 5'd7;
      step();
      chk("coll rd1",  oDataRead1, 32'h22);
      chk("coll err",  oErr,       1);
      chk("coll cnt",  oLdCount,   0);
      chk("coll mask", oBusyMask,  32'h400);

      // ALU write to a busy register: written, still busy, error raised.
      do_reset();
      @(negedge iCpuClock);
      iLdIssue = 1; iLdAddr = 5'd12;
      step();
      chk("wbusy pre err", oErr, 0);
      @(negedge iCpuClock);
      iWrEn = 1; iWrAddr = 5'd12; iWrData = 32'h77; iRs = 5'd12; iRt = 5'd0;
      step();
      chk("wbusy rd1",   oDataRead1, 32'h77);
      chk("wbusy stall", oStall,     1);
      chk("wbusy mask",  oBusyMask,  32'h1000);
      chk("wbusy err",   oErr,       1);

      // Second issue to a pending register (WAW).
      do_reset();
      @(negedge iCpuClock);
      iLdIssue = 1; iLdAddr = 5'd12;
      step();
      @(negedge iCpuClock);
      iLdIssue = 1; iLdAddr = 5'd12;
      step();
      chk("waw cnt",  oLdCount,  2);
      chk("waw mask", oBusyMask, 32'h1000);
      chk("waw err",  oErr,      1);

      // Loads to R0 are counted but never mark anything busy.
      do_reset();
      @(negedge iCpuClock);
      iLdIssue = 1; iLdAddr = 5'd0; iRs = 5'd0; iRt = 5'd0;
      step();
      chk("r0 cnt",   oLdCount,  1);
      chk("r0 mask",  oBusyMask, 0);
      chk("r0 stall", oStall,    0);
      @(negedge iCpuClock);
      iLdDone = 1; iLdDoneAddr = 5'd0; iLdData = 32'h55;
      step();
      chk("r0 done cnt", oLdCount,   0);
      chk("r0 done err", oErr,       0);
      chk("r0 done rd1", oDataRead1, 0);

      // Stall/read behaviour in the cycle the load returns.
      do_reset();
      @(negedge iCpuClock);
      iLdIssue = 1; iLdAddr = 5'd8;
      step();
      @(negedge iCpuClock);
      iLdDone = 1; iLdDoneAddr = 5'd8; iLdData = 32'hCAFE; iRs = 5'd8; iRt = 5'd0;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("done-cycle rd1",   oDataRead1, 32'hCAFE);
      chk("done-cycle stall", oStall,     0);
`else
      chk("done-cycle rd1",   oDataRead1, 0);
      chk("done-cycle stall", oStall,     1);
`endif
      step();
      chk("after-done rd1",   oDataRead1, 32'hCAFE);
      chk("after-done stall", oStall,     0);
      chk("after-done cnt",   oLdCount,   0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
